// File: rtl/ame_pri_la_pipe.sv
// ame_pri_la_pipe: leading-one window mask detector; AME_PRI_LA_ROUND_EN enables round-up of the window.
// Latency: 2 cycles from input handshake to out_valid_o, 1 word/cycle throughput.
// Backpressure: out_ready_i low stalls S2 then S1; in_ready_o drops once both stages hold a word.
module ame_pri_la_pipe #(
    parameter int WIDTH = 8,
    parameter int SPAN  = 2,
    localparam int POS_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_mask_o,
    output logic [POS_W-1:0] out_pos_o,
    output logic             out_zero_o,
    output logic [15:0]      zero_cnt_o
);

    // SPAN ones in the low bits; shifting left by the position clips at the MSB for free.
    localparam logic [WIDTH-1:0] WIN = {WIDTH{1'b1}} >> (WIDTH - SPAN);

    logic             rdy_en_q, rdy_en_d;
    logic             s1_vld_q, s1_vld_d;
    logic [POS_W-1:0] s1_pos_q, s1_pos_d;
    logic             s1_zero_q, s1_zero_d;
    logic             s2_vld_q, s2_vld_d;
    logic [WIDTH-1:0] s2_mask_q, s2_mask_d;
    logic [POS_W-1:0] s2_pos_q, s2_pos_d;
    logic             s2_zero_q, s2_zero_d;
    logic [15:0]      zero_cnt_q, zero_cnt_d;

    logic             s1_load;
    logic             s2_load;
    logic [POS_W-1:0] lo_pos;
    logic             lo_zero;
    logic [POS_W:0]   win_sh;

`ifdef AME_PRI_LA_ROUND_EN
    logic             lo_rnd;
    logic             s1_rnd_q, s1_rnd_d;
`endif

    // Leading-one search: the highest set bit wins because later iterations overwrite.
    always_comb begin
        lo_pos  = '0;
        lo_zero = ~|in_data_i;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_data_i[i]) begin
                lo_pos = POS_W'(i);
            end
        end
    end

`ifdef AME_PRI_LA_ROUND_EN
    always_comb begin
        lo_rnd = 1'b0;
        for (int i = 1; i < WIDTH; i++) begin
            if (in_data_i[i]) begin
                lo_rnd = in_data_i[i-1];
            end
        end
    end
`endif

    always_comb begin
        s2_load    = s1_vld_q && (!s2_vld_q || out_ready_i);
        in_ready_o = rdy_en_q && (!s1_vld_q || s2_load);
        s1_load    = in_valid_i && in_ready_o;

        rdy_en_d = 1'b1;
        s1_vld_d = s1_load || (s1_vld_q && !s2_load);
        s2_vld_d = s2_load || (s2_vld_q && !out_ready_i);

        s1_pos_d  = s1_load ? lo_pos  : s1_pos_q;
        s1_zero_d = s1_load ? lo_zero : s1_zero_q;
`ifdef AME_PRI_LA_ROUND_EN
        s1_rnd_d  = s1_load ? lo_rnd  : s1_rnd_q;
`endif

        zero_cnt_d = zero_cnt_q;
        if (s1_load && lo_zero && (zero_cnt_q != 16'hFFFF)) begin
            zero_cnt_d = zero_cnt_q + 16'd1;
        end
    end

    // Window placement for the word sitting in S1.
    always_comb begin
        win_sh = {1'b0, s1_pos_q};
`ifdef AME_PRI_LA_ROUND_EN
        if (s1_rnd_q && (s1_pos_q != POS_W'(WIDTH - 1))) begin
            win_sh = win_sh + {{POS_W{1'b0}}, 1'b1};
        end
`endif
        s2_mask_d = s2_mask_q;
        s2_pos_d  = s2_pos_q;
        s2_zero_d = s2_zero_q;
        if (s2_load) begin
            s2_mask_d = s1_zero_q ? '0 : (WIN << win_sh);
            s2_pos_d  = s1_zero_q ? '0 : s1_pos_q;
            s2_zero_d = s1_zero_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdy_en_q   <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_pos_q   <= '0;
            s1_zero_q  <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_mask_q  <= '0;
            s2_pos_q   <= '0;
            s2_zero_q  <= 1'b0;
            zero_cnt_q <= '0;
        end else begin
            rdy_en_q   <= rdy_en_d;
            s1_vld_q   <= s1_vld_d;
            s1_pos_q   <= s1_pos_d;
            s1_zero_q  <= s1_zero_d;
            s2_vld_q   <= s2_vld_d;
            s2_mask_q  <= s2_mask_d;
            s2_pos_q   <= s2_pos_d;
            s2_zero_q  <= s2_zero_d;
            zero_cnt_q <= zero_cnt_d;
        end
    end

`ifdef AME_PRI_LA_ROUND_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_rnd_q <= 1'b0;
        end else begin
            s1_rnd_q <= s1_rnd_d;
        end
    end
`endif

    assign out_valid_o = s2_vld_q;
    assign out_mask_o  = s2_mask_q;
    assign out_pos_o   = s2_pos_q;
    assign out_zero_o  = s2_zero_q;
    assign zero_cnt_o  = zero_cnt_q;

endmodule
